// File: rtl/adc_serial_ctrl_if.sv
// Datapath-side bus of the serial ADC controller: trigger controls in, word and strobes out.
`timescale 1ns/1ps
interface adc_serial_ctrl_if #(
    parameter int unsigned DATA_W = 16
);
    logic              start;
    logic              auto_en;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              frame_err;
    logic              timeout_err;

    // Datapath side: requests conversions, consumes words and strobes
    modport master (
        output start, auto_en,
        input  ready, data, data_valid, frame_err, timeout_err
    );

    // Controller side
    modport slave (
        input  start, auto_en,
        output ready, data, data_valid, frame_err, timeout_err
    );
endinterface

// File: rtl/adc_serial_ctrl.sv
// Conversion controller for an asynchronous busy/self-clocked serial ADC:
// triggers conversions, synchronizes busy/sclk/sdout and deserializes MSB-first words.
`timescale 1ns/1ps
module adc_serial_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 4096,
    parameter int unsigned AUTO_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst,
    adc_serial_ctrl_if.slave bus,
    output logic             adc_nconv,
    input  logic             adc_busy,
    input  logic             adc_sclk,
    input  logic             adc_sdout
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 2);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned TMR_W = $clog2(AUTO_PERIOD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_SHIFT,
        S_DONE,
        S_ABORT
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] busy_sync_q, busy_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdout_sync_q, sdout_sync_d;
    logic                   busy_prev_q, busy_prev_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   ready_q, ready_d;
    logic                   nconv_q, nconv_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   terr_q, terr_d;

    logic busy_s, sclk_s, sdout_s;
    logic busy_rise_c, busy_fall_c, sclk_rise_c;
    logic auto_tick_c, trig_c, tmo_hit_c;

    assign busy_s  = busy_sync_q[SYNC_STAGES-1];
    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign sdout_s = sdout_sync_q[SYNC_STAGES-1];

    assign busy_rise_c = busy_s & ~busy_prev_q;
    assign busy_fall_c = ~busy_s & busy_prev_q;
    assign sclk_rise_c = sclk_s & ~sclk_prev_q;

    assign auto_tick_c = bus.auto_en && (tmr_q == TMR_W'(AUTO_PERIOD - 1));
    assign trig_c      = bus.start || auto_tick_c;
    assign tmo_hit_c   = (tmo_q == TMO_W'(TIMEOUT - 1));

    assign bus.ready       = ready_q;
    assign bus.data        = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.frame_err   = ferr_q;
    assign bus.timeout_err = terr_q;
    assign adc_nconv       = nconv_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: busy edges take priority over a coincident timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (trig_c) state_d = S_CONV;
            S_CONV: begin
                if (busy_rise_c)    state_d = S_SHIFT;
                else if (tmo_hit_c) state_d = S_ABORT;
            end
            S_SHIFT: begin
                if (busy_fall_c)    state_d = S_DONE;
                else if (tmo_hit_c) state_d = S_ABORT;
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs, all derived from the state being entered
    always_comb begin
        busy_sync_d  = {busy_sync_q[SYNC_STAGES-2:0], adc_busy};
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], adc_sclk};
        sdout_sync_d = {sdout_sync_q[SYNC_STAGES-2:0], adc_sdout};
        busy_prev_d  = busy_s;
        sclk_prev_d  = sclk_s;
        tmr_d        = '0;
        tmo_d        = '0;
        cnt_d        = cnt_q;
        shift_d      = shift_q;

        if (bus.auto_en && !auto_tick_c) tmr_d = tmr_q + TMR_W'(1);

        if ((state_d == S_CONV || state_d == S_SHIFT) && state_d == state_q) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (state_q == S_IDLE && state_d == S_CONV) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (state_q == S_SHIFT && sclk_rise_c && cnt_q != CNT_W'(DATA_W + 1)) begin
            if (cnt_q < CNT_W'(DATA_W)) shift_d = {shift_q[DATA_W-2:0], sdout_s};
            cnt_d = cnt_q + CNT_W'(1);
        end

        ready_d = (state_d == S_IDLE);
        nconv_d = (state_d != S_CONV);
        valid_d = (state_d == S_DONE) && (cnt_d == CNT_W'(DATA_W));
        ferr_d  = (state_d == S_DONE) && (cnt_d != CNT_W'(DATA_W));
        terr_d  = (state_d == S_ABORT);
        data_d  = valid_d ? shift_d : data_q;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_sync_q  <= '0;
            sclk_sync_q  <= '0;
            sdout_sync_q <= '0;
            busy_prev_q  <= 1'b0;
            sclk_prev_q  <= 1'b0;
            tmr_q        <= '0;
            tmo_q        <= '0;
            cnt_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            ready_q      <= 1'b1;
            nconv_q      <= 1'b1;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            busy_sync_q  <= busy_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            sdout_sync_q <= sdout_sync_d;
            busy_prev_q  <= busy_prev_d;
            sclk_prev_q  <= sclk_prev_d;
            tmr_q        <= tmr_d;
            tmo_q        <= tmo_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            nconv_q      <= nconv_d;
            valid_q      <= valid_d;
            ferr_q       <= ferr_d;
            terr_q       <= terr_d;
        end
    end
endmodule

// File: tb/tb_adc_serial_ctrl.sv
// Bench for adc_serial_ctrl: ADC model on its own ~33 MHz clock, frame table with
// reference expectations, plus timeout, auto-trigger and reset-mid-frame sequences.
`timescale 1ns/1ps
module tb_adc_serial_ctrl;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned AUTO_PERIOD = 1000;
    localparam int unsigned TMO_SHORT   = 64;

    logic clk     = 1'b0;
    logic adc_clk = 1'b0;
    logic rst     = 1'b1;

    always #2.5   clk     = ~clk;
    always #15.15 adc_clk = ~adc_clk;

    adc_serial_ctrl_if #(.DATA_W(DATA_W)) bus ();
    adc_serial_ctrl_if #(.DATA_W(DATA_W)) bus_t ();

    logic adc_nconv;
    logic adc_busy  = 1'b0;
    logic adc_sclk  = 1'b0;
    logic adc_sdout = 1'b0;
    logic nconv_t;

    adc_serial_ctrl #(
        .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(4096), .AUTO_PERIOD(AUTO_PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .adc_nconv(adc_nconv),
        .adc_busy(adc_busy), .adc_sclk(adc_sclk), .adc_sdout(adc_sdout)
    );

    // Second instance with a short timeout and a dead ADC
    adc_serial_ctrl #(
        .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TMO_SHORT), .AUTO_PERIOD(AUTO_PERIOD)
    ) dut_t (
        .clk(clk), .rst(rst), .bus(bus_t), .adc_nconv(nconv_t),
        .adc_busy(1'b0), .adc_sclk(1'b0), .adc_sdout(1'b0)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ADC model: sees nconv low, raises busy, clocks out model_nbits bits MSB first
    int                model_nbits = 16;
    logic [DATA_W-1:0] model_word  = '0;

    always begin
        @(posedge adc_clk);
        if (!adc_nconv) begin
            @(posedge adc_clk);
            adc_busy = 1'b1;
            for (int i = 0; i < model_nbits; i++) begin
                adc_sdout = (i < int'(DATA_W)) ? model_word[DATA_W-1-i] : 1'($urandom);
                @(posedge adc_clk);
                adc_sclk = 1'b1;
                @(posedge adc_clk);
                adc_sclk = 1'b0;
            end
            @(posedge adc_clk);
            adc_busy = 1'b0;
        end
    end

    // Strobe monitor: pulse counts, exclusivity, single-cycle width, event times
    int   cyc = 0;
    int   n_valid = 0, n_ferr = 0, n_terr = 0;
    logic prev_strobe = 1'b0;
    logic prev_nconv  = 1'b1;
    int   valid_cyc[$];
    int   nconv_fall_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.data_valid || bus.frame_err || bus.timeout_err) begin
                check("strobe_exclusive", 32'($countones({bus.data_valid, bus.frame_err, bus.timeout_err})), 1);
                check("strobe_one_cycle", 32'(prev_strobe), 0);
            end
            if (bus.data_valid) begin
                n_valid++;
                valid_cyc.push_back(cyc);
            end
            if (bus.frame_err)   n_ferr++;
            if (bus.timeout_err) n_terr++;
            if (prev_nconv && !adc_nconv) nconv_fall_cyc.push_back(cyc);
        end
        prev_strobe = bus.data_valid || bus.frame_err || bus.timeout_err;
        prev_nconv  = adc_nconv;
    end

    // One on-demand conversion; returns the strobe seen and data at that cycle
    task automatic do_conv(input int nbits, input logic [DATA_W-1:0] word,
                           output logic dv, output logic fe, output logic [DATA_W-1:0] d,
                           output logic done);
        model_nbits = nbits;
        model_word  = word;
        dv = 1'b0; fe = 1'b0; d = '0; done = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.data_valid || bus.frame_err || bus.timeout_err) begin
                dv = bus.data_valid;
                fe = bus.frame_err;
                d  = bus.data;
                done = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int                nbits;
        logic [DATA_W-1:0] word;
        logic              exp_valid;
        logic              exp_ferr;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #400us;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic              dv, fe, done, seen;
        logic [DATA_W-1:0] d, ref_data;
        int                lat, edges, nb0, cnt, v0;
        logic              prev_s;

        // Table: hand-written entries, then random frames with expectations from the frame rule
        vecs.push_back('{12, 16'h1234, 1'b0, 1'b1, 16'hACCF});
        vecs.push_back('{18, 16'h5555, 1'b0, 1'b1, 16'hACCF});
        vecs.push_back('{16, 16'h1357, 1'b1, 1'b0, 16'h1357});
        vecs.push_back('{15, 16'hFFFF, 1'b0, 1'b1, 16'h1357});
        vecs.push_back('{17, 16'h0000, 1'b0, 1'b1, 16'h1357});
        vecs.push_back('{16, 16'h0000, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{16, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF});
        ref_data = 16'hFFFF;
        for (int r = 0; r < 6; r++) begin
            vec_t e;
            e.nbits = ($urandom_range(0, 1) == 0) ? int'(DATA_W) : int'($urandom_range(14, 18));
            e.word  = DATA_W'($urandom);
            e.exp_valid = (e.nbits == int'(DATA_W));
            e.exp_ferr  = !e.exp_valid;
            if (e.exp_valid) ref_data = e.word;
            e.exp_data = ref_data;
            vecs.push_back(e);
        end

        bus.start = 1'b0; bus.auto_en = 1'b0;
        bus_t.start = 1'b0; bus_t.auto_en = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.ready, 1);
        check("rst_nconv", adc_nconv, 1);
        check("rst_data", bus.data, 0);
        check("rst_valid", bus.data_valid, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_terr", bus.timeout_err, 0);

        // First conversion: nconv low only until busy is seen, then word 0xACCF
        model_nbits = 16; model_word = 16'hACCF;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        check("conv_nconv_low", adc_nconv, 0);
        check("conv_ready_low", bus.ready, 0);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (adc_busy) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("busy_seen", seen, 1);
        check("nconv_low_at_busy", adc_nconv, 0);
        lat = 0;
        while (adc_nconv && lat < 0) lat++;
        for (int k = 0; k < 20 && !adc_nconv; k++) begin
            @(negedge clk);
            lat++;
        end
        check("nconv_release_latency", 32'((lat >= 1) && (lat <= int'(SYNC_STAGES) + 2)), 1);
        done = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.data_valid || bus.frame_err) begin
                done = 1'b1;
                dv = bus.data_valid;
                d  = bus.data;
                check("first_ready_low_at_strobe", bus.ready, 0);
                break;
            end
        end
        check("first_done", done, 1);
        check("first_valid", dv, 1);
        check("first_data", d, 16'hACCF);
        @(negedge clk);
        check("first_ready_after", bus.ready, 1);
        check("first_valid_cleared", bus.data_valid, 0);

        // Table-driven frames
        for (int v = 0; v < vecs.size(); v++) begin
            do_conv(vecs[v].nbits, vecs[v].word, dv, fe, d, done);
            check($sformatf("vec%0d_done", v), done, 1);
            check($sformatf("vec%0d_valid", v), dv, vecs[v].exp_valid);
            check($sformatf("vec%0d_ferr", v), fe, vecs[v].exp_ferr);
            check($sformatf("vec%0d_data", v), d, vecs[v].exp_data);
            @(negedge clk);
            check($sformatf("vec%0d_ready", v), bus.ready, 1);
            check($sformatf("vec%0d_data_hold", v), bus.data, vecs[v].exp_data);
        end

        // Timeout: dead ADC, nconv held low for TIMEOUT cycles then one timeout_err
        @(negedge clk); bus_t.start = 1'b1;
        @(negedge clk); bus_t.start = 1'b0;
        check("tmo_nconv_low", nconv_t, 0);
        cnt = 1;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus_t.timeout_err) begin seen = 1'b1; break; end
            cnt++;
        end
        check("tmo_seen", seen, 1);
        check("tmo_latency", cnt, TMO_SHORT);
        check("tmo_nconv_high", nconv_t, 1);
        check("tmo_no_other_strobe", {bus_t.data_valid, bus_t.frame_err}, 0);
        @(negedge clk);
        check("tmo_ready_after", bus_t.ready, 1);
        check("tmo_strobe_cleared", bus_t.timeout_err, 0);
        check("tmo_data_untouched", bus_t.data, 0);

        // Auto trigger for ~5 periods with a start request dropped in SHIFT
        model_nbits = 16; model_word = 16'h5A3C;
        v0  = n_valid;
        nb0 = n_ferr + n_terr;
        @(negedge clk); bus.auto_en = 1'b1;
        for (int i = 0; i < 5050; i++) begin
            @(negedge clk);
            if (i == 1080) begin
                check("auto_busy_during_start", {bus.ready, adc_busy}, 2'b01);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
        end
        bus.auto_en = 1'b0;
        repeat (500) @(negedge clk);
        check("auto_valid_count", n_valid - v0, 5);
        check("auto_no_errors", n_ferr + n_terr - nb0, 0);
        check("auto_data", bus.data, 16'h5A3C);
        if (nconv_fall_cyc.size() >= 5 && valid_cyc.size() >= 5) begin
            for (int j = 1; j < 5; j++) begin
                int a, b;
                a = nconv_fall_cyc[nconv_fall_cyc.size() - 5 + j] - nconv_fall_cyc[nconv_fall_cyc.size() - 6 + j];
                b = valid_cyc[valid_cyc.size() - 5 + j] - valid_cyc[valid_cyc.size() - 6 + j];
                check($sformatf("auto_trigger_spacing%0d", j), a, AUTO_PERIOD);
                check($sformatf("auto_valid_spacing%0d", j), 32'((b >= 988) && (b <= 1012)), 1);
            end
        end else begin
            check("auto_event_history", nconv_fall_cyc.size(), 5);
        end

        // Reset after 8 sclk edges: reset values next cycle, rest of frame ignored
        model_nbits = 16; model_word = 16'hACCF;
        nb0 = n_valid + n_ferr + n_terr;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        edges  = 0;
        prev_s = adc_sclk;
        for (int k = 0; k < 2000 && edges < 8; k++) begin
            @(negedge clk);
            if (adc_sclk && !prev_s) edges++;
            prev_s = adc_sclk;
        end
        check("midrst_edges", edges, 8);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", bus.ready, 1);
        check("midrst_nconv", adc_nconv, 1);
        check("midrst_data", bus.data, 0);
        check("midrst_strobes", {bus.data_valid, bus.frame_err, bus.timeout_err}, 0);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        check("midrst_no_strobes", n_valid + n_ferr + n_terr, nb0);
        check("midrst_idle", {bus.ready, adc_nconv}, 2'b11);
        check("midrst_data_after", bus.data, 0);
        do_conv(16, 16'hACCF, dv, fe, d, done);
        check("postrst_done", done, 1);
        check("postrst_valid", dv, 1);
        check("postrst_data", d, 16'hACCF);

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
